at24_ctrl: RTL and testbench

//  Protocol engine between the I2C slave byte streams and the EEPROM storage array.

---
 rtl/at24_pkg.sv | 19 +
 rtl/at24_addr_ptr.sv | 45 ++++
 rtl/at24_ctrl.sv | 141 ++++++++++++++
 tb/tb_at24_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/at24_pkg.sv
// Shared types and helpers for the AT24-style EEPROM protocol engine.
package at24_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_e;

  // Number of in-page pointer bits for a power-of-two page size.
  function automatic int unsigned page_w(input int unsigned page_size);
    return $clog2(page_size);
  endfunction

endpackage

// File: rtl/at24_addr_ptr.sv
// Word address pointer: load from an address byte, wrap inside a page on
// data writes, or advance linearly across the whole array on reads.
module at24_addr_ptr #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned PAGE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              page_inc,
  input  logic              lin_inc,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((1 << PAGE_W) - 1);

  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_inc;

  // Page increment keeps the page bits and wraps only the in-page offset.
  always_comb begin
    ptr_inc = ptr_q + ADDR_W'(1);
    ptr_d   = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (page_inc) begin
      ptr_d = (ptr_q & ~PAGE_MASK) | (ptr_inc & PAGE_MASK);
    end else if (lin_inc) begin
      ptr_d = ptr_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/at24_ctrl.sv
// Protocol engine between the I2C slave byte streams and the EEPROM array.
// Optional write-protect input is enabled with `define AT24_WP_EN.
module at24_ctrl
  import at24_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned PAGE_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_tdata,
  input  logic              rx_tvalid,
  output logic              rx_tready,
  input  logic              rx_tlast,
  output logic [7:0]        tx_tdata,
  output logic              tx_tvalid,
  input  logic              tx_tready,
  output logic              tx_tlast,
  input  logic              bus_addressed,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
`ifdef AT24_WP_EN
  ,
  input  logic              wp
`endif
);

  localparam int unsigned PAGE_W = page_w(PAGE_SIZE);

  state_e            state_q, state_d;
  byte_t             tx_tdata_q, tx_tdata_d;
  logic              tx_tvalid_q, tx_tvalid_d;
  logic              rx_tready_q, rx_tready_d;
  logic              expect_addr_q, expect_addr_d;
  logic              bus_addressed_q;
  logic [ADDR_W-1:0] ptr;
  logic              rx_hs, tx_hs;
  logic              ptr_load, ptr_page_inc, ptr_lin_inc;
  logic              wr_en, wr_block;
  logic              unused_rx_tlast;

  assign unused_rx_tlast = rx_tlast;

`ifdef AT24_WP_EN
  assign wr_block = wp;
`else
  assign wr_block = 1'b0;
`endif

  assign rx_hs = (state_q == READY) && rx_tvalid && rx_tready_q;
  assign tx_hs = (state_q == READY) && tx_tvalid_q && tx_tready;

  // Fetch/present/serve loop; an rx byte takes priority over a tx handshake.
  always_comb begin
    state_d       = state_q;
    tx_tdata_d    = tx_tdata_q;
    tx_tvalid_d   = tx_tvalid_q;
    expect_addr_d = expect_addr_q;
    ptr_load      = 1'b0;
    ptr_page_inc  = 1'b0;
    ptr_lin_inc   = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      FETCH: state_d = WAIT;
      WAIT: begin
        tx_tdata_d  = mem_rdata;
        tx_tvalid_d = 1'b1;
        state_d     = READY;
      end
      READY: begin
        if (rx_hs) begin
          tx_tvalid_d = 1'b0;
          state_d     = FETCH;
          if (expect_addr_q) begin
            ptr_load      = 1'b1;
            expect_addr_d = 1'b0;
          end else begin
            ptr_page_inc = 1'b1;
            wr_en        = !wr_block;
          end
        end else if (tx_hs) begin
          ptr_lin_inc = 1'b1;
          tx_tvalid_d = 1'b0;
          state_d     = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    // A new addressing phase always expects a word address first.
    if (bus_addressed && !bus_addressed_q) begin
      expect_addr_d = 1'b1;
    end
    rx_tready_d = (state_d == READY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= FETCH;
      tx_tdata_q      <= '0;
      tx_tvalid_q     <= 1'b0;
      rx_tready_q     <= 1'b0;
      expect_addr_q   <= 1'b0;
      bus_addressed_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      tx_tdata_q      <= tx_tdata_d;
      tx_tvalid_q     <= tx_tvalid_d;
      rx_tready_q     <= rx_tready_d;
      expect_addr_q   <= expect_addr_d;
      bus_addressed_q <= bus_addressed;
    end
  end

  at24_addr_ptr #(
    .ADDR_W (ADDR_W),
    .PAGE_W (PAGE_W)
  ) u_addr_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (ptr_load),
    .load_val (ADDR_W'(rx_tdata)),
    .page_inc (ptr_page_inc),
    .lin_inc  (ptr_lin_inc),
    .ptr      (ptr)
  );

  // Storage strobes follow the state directly so a write lands in the handshake cycle.
  assign mem_re    = !rst && (state_q == FETCH);
  assign mem_we    = !rst && wr_en;
  assign mem_addr  = rst ? '0 : ptr;
  assign mem_wdata = mem_we ? rx_tdata : '0;

  assign rx_tready = rx_tready_q;
  assign tx_tdata  = tx_tdata_q;
  assign tx_tvalid = tx_tvalid_q;
  assign tx_tlast  = 1'b0;

endmodule

// File: tb/tb_at24_ctrl.sv
// Self-checking bench for at24_ctrl: directed vectors plus randomized
// transactions checked against a transaction-level EEPROM model.
`timescale 1ns/1ps
module tb_at24_ctrl;
  import at24_pkg::*;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned PAGE_SIZE = 8;
  localparam int unsigned DEPTH     = 256;
  localparam int          BUDGET    = 50;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_tdata = '0;
  logic              rx_tvalid = 1'b0;
  logic              rx_tready;
  logic              rx_tlast = 1'b0;
  logic [7:0]        tx_tdata;
  logic              tx_tvalid;
  logic              tx_tready = 1'b0;
  logic              tx_tlast;
  logic              bus_addressed = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata = '0;
  logic              wp = 1'b0;

  always #5 clk = ~clk;

  at24_ctrl #(.ADDR_W(ADDR_W), .PAGE_SIZE(PAGE_SIZE)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_tdata      (rx_tdata),
    .rx_tvalid     (rx_tvalid),
    .rx_tready     (rx_tready),
    .rx_tlast      (rx_tlast),
    .tx_tdata      (tx_tdata),
    .tx_tvalid     (tx_tvalid),
    .tx_tready     (tx_tready),
    .tx_tlast      (tx_tlast),
    .bus_addressed (bus_addressed),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .mem_rdata     (mem_rdata)
`ifdef AT24_WP_EN
    ,
    .wp            (wp)
`endif
  );

  // Model state: expected array contents, pointer and address-phase flag.
  byte_t m_mem [DEPTH];
  int    m_ptr = 0;
  bit    m_expect = 1'b0;
  int    m_writes = 0;

  // Storage array seen by the DUT (1-cycle read latency).
  byte_t mem [DEPTH];
  bit    load_mem = 1'b0;
  int    wr_count = 0;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= m_mem[i];
    end else begin
      if (mem_re) mem_rdata <= mem[mem_addr];
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        wr_count++;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(rx_tvalid && rx_tready && tx_tvalid && tx_tready))
        else $error("illegal simultaneous rx/tx handshake");
    end
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] last_waddr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int page_next(input int p);
    return (p / PAGE_SIZE) * PAGE_SIZE + ((p % PAGE_SIZE) + 1) % PAGE_SIZE;
  endfunction

  task automatic start_txn();
    bus_addressed = 1'b0;
    step();
    bus_addressed = 1'b1;
    step();
    m_expect = 1'b1;
  endtask

  task automatic stop_txn();
    bus_addressed = 1'b0;
    step();
  endtask

  // Master writes one byte; the storage strobe is checked in the handshake cycle.
  task automatic send_rx(input byte_t b, input string tag);
    int n = 0;
    rx_tdata  = b;
    rx_tvalid = 1'b1;
    #1;
    while (!rx_tready && n < BUDGET) begin
      step();
      n++;
    end
    if (!rx_tready) begin
      check({tag, " rx_ready"}, rx_tready, 1);
      rx_tvalid = 1'b0;
      return;
    end
    if (m_expect) begin
      check({tag, " addr_no_we"}, mem_we, 0);
      m_ptr    = b % DEPTH;
      m_expect = 1'b0;
    end else begin
      check({tag, " we"}, mem_we, !wp);
      if (!wp) begin
        check({tag, " waddr"}, mem_addr, m_ptr);
        check({tag, " wdata"}, mem_wdata, b);
        last_waddr = mem_addr;
        m_mem[m_ptr] = b;
        m_writes++;
      end
      m_ptr = page_next(m_ptr);
    end
    step();
    rx_tvalid = 1'b0;
  endtask

  // Master reads one byte; it must equal the model array at the model pointer.
  task automatic recv_tx(output byte_t got, input string tag);
    int n = 0;
    tx_tready = 1'b1;
    #1;
    while (!tx_tvalid && n < BUDGET) begin
      step();
      n++;
    end
    got = tx_tdata;
    if (!tx_tvalid) begin
      check({tag, " tx_valid"}, tx_tvalid, 1);
      tx_tready = 1'b0;
      return;
    end
    check({tag, " rdata"}, tx_tdata, m_mem[m_ptr]);
    m_ptr = (m_ptr + 1) % DEPTH;
    step();
    tx_tready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " tx_tvalid"}, tx_tvalid, 0);
    check({tag, " tx_tdata"},  tx_tdata, 0);
    check({tag, " rx_tready"}, rx_tready, 0);
    check({tag, " mem_we"},    mem_we, 0);
    check({tag, " mem_re"},    mem_re, 0);
    check({tag, " mem_addr"},  mem_addr, 0);
    check({tag, " mem_wdata"}, mem_wdata, 0);
  endtask

  typedef struct packed {
    logic [7:0]      addr;
    int              n;
    logic [2:0][7:0] data;
    logic [2:0][7:0] waddr;
    logic [7:0]      end_ptr;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t  vecs [4];
    byte_t got;
    int    re_cyc [3];
    byte_t rd [3];
    int    re_cnt, nhs, c, mism, wr_before;

    vecs[0] = '{addr: 8'h10, n: 2, data: {8'h00, 8'hBB, 8'hAA},
                waddr: {8'h00, 8'h11, 8'h10}, end_ptr: 8'h12};
    vecs[1] = '{addr: 8'h06, n: 3, data: {8'h03, 8'h02, 8'h01},
                waddr: {8'h00, 8'h07, 8'h06}, end_ptr: 8'h01};
    vecs[2] = '{addr: 8'hFE, n: 3, data: {8'h3C, 8'hA5, 8'h5A},
                waddr: {8'hF8, 8'hFF, 8'hFE}, end_ptr: 8'hF9};
    vecs[3] = '{addr: 8'h80, n: 0, data: '0, waddr: '0, end_ptr: 8'h80};

    for (int i = 0; i < DEPTH; i++) m_mem[i] = byte_t'($urandom);

    // Reset state, with the storage preload done under reset.
    rst = 1'b1;
    load_mem = 1'b1;
    step();
    load_mem = 1'b0;
    step();
    check_reset_outputs("reset");
    check("tx_tlast", tx_tlast, 0);

    // Free-running reads from address 0 with tx_tready held high.
    rst = 1'b0;
    tx_tready = 1'b1;
    #1;
    re_cnt = 0;
    nhs = 0;
    c = 0;
    while (nhs < 3 && c < BUDGET) begin
      if (mem_re && re_cnt < 3) begin
        re_cyc[re_cnt] = c;
        re_cnt++;
      end
      if (tx_tvalid && tx_tready) begin
        rd[nhs] = tx_tdata;
        nhs++;
      end
      step();
      c++;
    end
    tx_tready = 1'b0;
    check("boot reads", nhs, 3);
    check("boot re count", re_cnt, 3);
    check("boot first re", re_cyc[0], 0);
    check("boot re cadence1", re_cyc[1] - re_cyc[0], 3);
    check("boot re cadence2", re_cyc[2] - re_cyc[1], 3);
    for (int i = 0; i < 3; i++) check($sformatf("boot byte%0d", i), rd[i], m_mem[i]);
    m_ptr = 3;

    // Directed page writes followed by a current-address read.
    for (int v = 0; v < 4; v++) begin
      start_txn();
      send_rx(vecs[v].addr, $sformatf("vec%0d addr", v));
      for (int i = 0; i < vecs[v].n; i++) begin
        send_rx(vecs[v].data[i], $sformatf("vec%0d d%0d", v, i));
        check($sformatf("vec%0d waddr%0d", v, i), last_waddr, vecs[v].waddr[i]);
      end
      stop_txn();
      start_txn();
      recv_tx(got, $sformatf("vec%0d read", v));
      check($sformatf("vec%0d end_ptr", v), got, m_mem[vecs[v].end_ptr]);
      stop_txn();
    end

    // Random read across the top of the array.
    start_txn();
    send_rx(8'hFF, "rand_rd addr");
    stop_txn();
    start_txn();
    recv_tx(got, "rand_rd r0");
    check("rand_rd ff", got, m_mem[8'hFF]);
    recv_tx(got, "rand_rd r1");
    check("rand_rd 00", got, m_mem[8'h00]);
    stop_txn();

    // Held read data is dropped when a write changes the pointer.
    start_txn();
    send_rx(8'h20, "stale addr20");
    stop_txn();
    step();
    step();
    check("stale held valid", tx_tvalid, 1);
    check("stale held data", tx_tdata, m_mem[8'h20]);
    start_txn();
    send_rx(8'h40, "stale addr40");
    check("stale drop", tx_tvalid, 0);
    recv_tx(got, "stale reread");
    check("stale new data", got, m_mem[8'h40]);
    stop_txn();

`ifdef AT24_WP_EN
    wr_before = wr_count;
    start_txn();
    send_rx(8'h30, "wp addr");
    wp = 1'b1;
    send_rx(8'h55, "wp data");
    wp = 1'b0;
    stop_txn();
    check("wp no strobe", wr_count, wr_before);
    start_txn();
    recv_tx(got, "wp ptr31");
    check("wp ptr31 data", got, m_mem[8'h31]);
    stop_txn();
    start_txn();
    send_rx(8'h30, "wp readback addr");
    stop_txn();
    start_txn();
    recv_tx(got, "wp readback");
    stop_txn();
`endif

    // Reset in the middle of a page write abandons it.
    start_txn();
    send_rx(8'h50, "rst addr");
    send_rx(8'h77, "rst d0");
    wr_before = wr_count;
    rx_tdata  = 8'h99;
    rx_tvalid = 1'b1;
    rst = 1'b1;
    bus_addressed = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst we%0d", i), mem_we, 0);
      step();
    end
    check_reset_outputs("midrst");
    rx_tvalid = 1'b0;
    rst = 1'b0;
    m_ptr = 0;
    m_expect = 1'b0;
    step();
    check("rst no strobe", wr_count, wr_before);
    recv_tx(got, "rst read0");

    // Randomized transactions against the model.
    for (int t = 0; t < 30; t++) begin
      int op;
      op = int'($urandom_range(0, 2));
      start_txn();
      if (op == 0) begin
        int n;
        send_rx(byte_t'($urandom), $sformatf("rnd%0d addr", t));
        n = int'($urandom_range(0, 10));
        for (int i = 0; i < n; i++) begin
`ifdef AT24_WP_EN
          wp = ($urandom_range(0, 3) == 0);
`endif
          send_rx(byte_t'($urandom), $sformatf("rnd%0d d%0d", t, i));
        end
        wp = 1'b0;
      end else if (op == 1) begin
        int n;
        n = int'($urandom_range(1, 4));
        for (int i = 0; i < n; i++) recv_tx(got, $sformatf("rnd%0d cur%0d", t, i));
      end else begin
        int n;
        send_rx(byte_t'($urandom), $sformatf("rnd%0d raddr", t));
        stop_txn();
        start_txn();
        n = int'($urandom_range(1, 3));
        for (int i = 0; i < n; i++) recv_tx(got, $sformatf("rnd%0d rr%0d", t, i));
      end
      stop_txn();
    end

    // Final array image and strobe count.
    step();
    mism = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== m_mem[i]) mism++;
    end
    check("mem image mismatches", mism, 0);
    check("write strobe count", wr_count, m_writes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
